// File: rtl/fm_op_eg_update.sv
// fm_op_eg_update: per-slot envelope generator step, two-cycle read-modify-write on an external EG state RAM.
// Optional build macro FM_EG_ATTACK_BYPASS_EN: ar=15 in attack jumps straight to zero attenuation.
module fm_op_eg_update #(
    parameter int unsigned NUM_SLOTS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [5:0]  i_idx,
    input  logic        i_key_on,
    input  logic        i_egt,
    input  logic [3:0]  i_ar,
    input  logic [3:0]  i_dr,
    input  logic [3:0]  i_rr,
    input  logic [3:0]  i_sl,
    output logic        o_ready,
    output logic [5:0]  o_ram_idx,
    output logic        o_ram_wren,
    output logic [1:0]  o_ram_stage,
    output logic [23:0] o_ram_env_cnt,
    input  logic [1:0]  i_ram_stage,
    input  logic [23:0] i_ram_env_cnt,
    output logic        o_valid,
    output logic [5:0]  o_idx,
    output logic [9:0]  o_atten
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam logic [1:0] STG_ATTACK  = 2'd0;
    localparam logic [1:0] STG_DECAY   = 2'd1;
    localparam logic [1:0] STG_SUSTAIN = 2'd2;
    localparam logic [1:0] STG_RELEASE = 2'd3;

    localparam logic [6:0] SLOT_LIMIT = 7'(NUM_SLOTS);

    logic [0:0]  state_q, state_d;
    logic [5:0]  idx_q;
    logic        key_q, egt_q;
    logic [3:0]  ar_q, dr_q, rr_q, sl_q;
    logic [1:0]  stage_q;
    logic [23:0] env_q;
    logic [63:0] hist_q;
    logic        valid_q;
    logic [5:0]  oidx_q;
    logic [9:0]  atten_q;

    logic        accept;
    logic        writing;
    logic        hist_bit;
    logic        attack_bypass;
    logic [1:0]  stage_eff;
    logic [1:0]  stage_new;
    logic [23:0] env_new;
    logic [24:0] env_sum;

    function automatic logic [24:0] rate_inc(input logic [3:0] r);
        rate_inc = (r == 4'd0) ? '0 : (25'd1 << ({1'b0, r} + 5'd4));
    endfunction

`ifdef FM_EG_ATTACK_BYPASS_EN
    assign attack_bypass = (ar_q == 4'hF);
`else
    assign attack_bypass = 1'b0;
`endif

    assign writing   = (state_q == ST_WRITE);
    assign accept    = (state_q == ST_IDLE) && i_start && ({1'b0, i_idx} < SLOT_LIMIT);
    assign hist_bit  = hist_q[idx_q];

    assign o_ready       = !writing;
    assign o_ram_wren    = writing;
    assign o_ram_idx     = writing ? idx_q : i_idx;
    assign o_ram_stage   = stage_new;
    assign o_ram_env_cnt = env_new;
    assign o_valid       = valid_q;
    assign o_idx         = oidx_q;
    assign o_atten       = atten_q;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_WRITE;
        end else if (writing) begin
            state_d = ST_IDLE;
        end
    end

    // Key edges override the stored stage before the stage step; key-on wins.
    always_comb begin
        stage_eff = stage_q;
        if (key_q && !hist_bit) begin
            stage_eff = STG_ATTACK;
        end else if (!key_q && hist_bit) begin
            stage_eff = STG_RELEASE;
        end
        stage_new = stage_eff;
        env_new   = env_q;
        env_sum   = {1'b0, env_q};
        case (stage_eff)
            STG_ATTACK: begin
                env_sum = {1'b0, env_q} - rate_inc(ar_q);
                if (attack_bypass || env_sum[24] || (env_sum == '0)) begin
                    env_new   = '0;
                    stage_new = STG_DECAY;
                end else begin
                    env_new = env_sum[23:0];
                end
            end
            STG_DECAY: begin
                env_sum = {1'b0, env_q} + rate_inc(dr_q);
                if (env_sum >= {1'b0, sl_q, 20'h0}) begin
                    env_new   = {sl_q, 20'h0};
                    stage_new = STG_SUSTAIN;
                end else begin
                    env_new = env_sum[23:0];
                end
            end
            STG_SUSTAIN: begin
                if (!egt_q) begin
                    stage_new = STG_RELEASE;
                end
            end
            default: begin
                env_sum = {1'b0, env_q} + rate_inc(rr_q);
                env_new = env_sum[24] ? '1 : env_sum[23:0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            key_q   <= 1'b0;
            egt_q   <= 1'b0;
            ar_q    <= '0;
            dr_q    <= '0;
            rr_q    <= '0;
            sl_q    <= '0;
            stage_q <= '0;
            env_q   <= '0;
            hist_q  <= '0;
            valid_q <= 1'b0;
            oidx_q  <= '0;
            atten_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (accept) begin
                idx_q   <= i_idx;
                key_q   <= i_key_on;
                egt_q   <= i_egt;
                ar_q    <= i_ar;
                dr_q    <= i_dr;
                rr_q    <= i_rr;
                sl_q    <= i_sl;
                stage_q <= i_ram_stage;
                env_q   <= i_ram_env_cnt;
            end
            if (writing) begin
                hist_q[idx_q] <= key_q;
                valid_q       <= 1'b1;
                oidx_q        <= idx_q;
                atten_q       <= env_new[23:14];
            end
        end
    end
endmodule
